// File: rtl/actuator_pkg.sv
// Shared codes for the actuator driver: motor commands, steering codes and motor FSM states.
package actuator_pkg;

    typedef enum logic [1:0] {
        MOT_STOP  = 2'b00,
        MOT_FWD   = 2'b01,
        MOT_BWD   = 2'b10,
        MOT_BRAKE = 2'b11
    } mot_cmd_e;

    typedef enum logic [2:0] {
        STEER_FULL_L = 3'd0,
        STEER_HALF_L = 3'd1,
        STEER_CENTER = 3'd2,
        STEER_HALF_R = 3'd3,
        STEER_FULL_R = 3'd4
    } steer_e;

    typedef enum logic [2:0] {
        S_STOP,
        S_FWD,
        S_BWD,
        S_BRAKE,
        S_DEAD
    } state_e;

endpackage

// File: rtl/pwm_gen.sv
// Period counter plus compare; the compare width can be latched at the period boundary (LATCH=1).
// The wrap strobe is only exported when ACTUATOR_SOFT_START_EN is defined.
module pwm_gen #(
    parameter int unsigned PERIOD    = 100,
    parameter int unsigned W         = $clog2(PERIOD + 1),
    parameter bit          LATCH     = 1'b0,
    parameter int unsigned RST_WIDTH = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] width,
    output logic         pwm
`ifdef ACTUATOR_SOFT_START_EN
    ,
    output logic         wrap
`endif
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] width_q, width_d;
    logic         pwm_q, pwm_d;
    logic         at_end;

    // Output is registered one cycle behind the counter so reset drives it low
    always_comb begin
        at_end  = (cnt_q == W'(PERIOD - 1));
        cnt_d   = at_end ? '0 : cnt_q + W'(1);
        width_d = at_end ? width : width_q;
        pwm_d   = (cnt_q < (LATCH ? width_q : width));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            width_q <= W'(RST_WIDTH);
            pwm_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            width_q <= width_d;
            pwm_q   <= pwm_d;
        end
    end

    assign pwm = pwm_q;
`ifdef ACTUATOR_SOFT_START_EN
    assign wrap = at_end;
`endif

endmodule

// File: rtl/actuator_driver.sv
// Servo PWM and H-bridge driver with reversal dead-time.
// Optional motor soft-start ramp: define ACTUATOR_SOFT_START_EN.
module actuator_driver
    import actuator_pkg::*;
#(
    parameter int unsigned SERVO_PERIOD = 10000,
    parameter int unsigned SERVO_MIN    = 500,
    parameter int unsigned SERVO_HALF_L = 625,
    parameter int unsigned SERVO_CENTER = 750,
    parameter int unsigned SERVO_HALF_R = 875,
    parameter int unsigned SERVO_MAX    = 1000,
    parameter int unsigned MOTOR_PERIOD = 100,
    parameter int unsigned MOTOR_DUTY   = 70,
    parameter int unsigned DEAD_CYCLES  = 500
`ifdef ACTUATOR_SOFT_START_EN
    ,
    parameter int unsigned RAMP_STEP    = 10
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] front_wheel,
    input  logic [1:0] motor,
    output logic       servo_pwm,
    output logic       motor_in1,
    output logic       motor_in2,
    output logic       motor_en,
    output logic       dead_active
);

    localparam int unsigned SW = $clog2(SERVO_PERIOD + 1);
    localparam int unsigned MW = $clog2(MOTOR_PERIOD + 1);
    localparam int unsigned DW = $clog2(DEAD_CYCLES + 1);

    logic [2:0]    fw_q, fw_d;
    mot_cmd_e      cmd_q, cmd_d;
    state_e        state_q, state_d;
    logic [DW-1:0] dead_q, dead_d;
    logic [SW-1:0] servo_width;
    logic [MW-1:0] mot_width;
    logic          mot_pwm;
    logic          want_fwd;

    always_comb begin
        fw_d  = front_wheel;
        cmd_d = mot_cmd_e'(motor);
        case (fw_q)
            STEER_FULL_L: servo_width = SW'(SERVO_MIN);
            STEER_HALF_L: servo_width = SW'(SERVO_HALF_L);
            STEER_HALF_R: servo_width = SW'(SERVO_HALF_R);
            STEER_FULL_R: servo_width = SW'(SERVO_MAX);
            default:      servo_width = SW'(SERVO_CENTER);
        endcase
    end

    always_comb begin
        state_d  = state_q;
        dead_d   = dead_q;
        want_fwd = (cmd_q == MOT_FWD);
        case (cmd_q)
            MOT_STOP:  state_d = S_STOP;
            MOT_BRAKE: state_d = S_BRAKE;
            default: begin
                case (state_q)
                    // Direction is only chosen at expiry, so re-requesting the old one still waits
                    S_DEAD: begin
                        if (dead_q == '0) state_d = want_fwd ? S_FWD : S_BWD;
                        else              dead_d  = dead_q - DW'(1);
                    end
                    S_FWD: begin
                        if (!want_fwd) begin
                            state_d = S_DEAD;
                            dead_d  = DW'(DEAD_CYCLES - 1);
                        end
                    end
                    S_BWD: begin
                        if (want_fwd) begin
                            state_d = S_DEAD;
                            dead_d  = DW'(DEAD_CYCLES - 1);
                        end
                    end
                    default: state_d = want_fwd ? S_FWD : S_BWD;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fw_q    <= '0;
            cmd_q   <= MOT_STOP;
            state_q <= S_STOP;
            dead_q  <= '0;
        end else begin
            fw_q    <= fw_d;
            cmd_q   <= cmd_d;
            state_q <= state_d;
            dead_q  <= dead_d;
        end
    end

`ifdef ACTUATOR_SOFT_START_EN
    logic [MW-1:0] duty_q, duty_d;
    logic [31:0]   duty_sum;
    logic          mot_wrap;
    logic          run_now, run_next;

    always_comb begin
        run_now  = (state_q == S_FWD) || (state_q == S_BWD);
        run_next = (state_d == S_FWD) || (state_d == S_BWD);
        duty_sum = 32'(duty_q) + RAMP_STEP;
        duty_d   = duty_q;
        if (run_next && !run_now)
            duty_d = '0;
        else if (run_now && mot_wrap)
            duty_d = (duty_sum >= MOTOR_DUTY) ? MW'(MOTOR_DUTY) : MW'(duty_sum);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) duty_q <= '0;
        else      duty_q <= duty_d;
    end

    assign mot_width = duty_q;
`else
    assign mot_width = MW'(MOTOR_DUTY);
`endif

    pwm_gen #(
        .PERIOD    (SERVO_PERIOD),
        .W         (SW),
        .LATCH     (1'b1),
        .RST_WIDTH (SERVO_CENTER)
    ) u_servo_pwm (
        .clk   (clk),
        .rst_n (rst),
        .width (servo_width),
        .pwm   (servo_pwm)
`ifdef ACTUATOR_SOFT_START_EN
        ,
        .wrap  ()
`endif
    );

    pwm_gen #(
        .PERIOD    (MOTOR_PERIOD),
        .W         (MW),
        .LATCH     (1'b0),
        .RST_WIDTH (0)
    ) u_motor_pwm (
        .clk   (clk),
        .rst_n (rst),
        .width (mot_width),
        .pwm   (mot_pwm)
`ifdef ACTUATOR_SOFT_START_EN
        ,
        .wrap  (mot_wrap)
`endif
    );

    always_comb begin
        motor_in1   = 1'b0;
        motor_in2   = 1'b0;
        motor_en    = 1'b0;
        dead_active = 1'b0;
        case (state_q)
            S_FWD: begin
                motor_in1 = 1'b1;
                motor_en  = mot_pwm;
            end
            S_BWD: begin
                motor_in2 = 1'b1;
                motor_en  = mot_pwm;
            end
            S_BRAKE: begin
                motor_in1 = 1'b1;
                motor_in2 = 1'b1;
                motor_en  = 1'b1;
            end
            S_DEAD:  dead_active = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_actuator_driver.sv
// Directed self-checking bench for actuator_driver (default parameters, soft start disabled).
module tb_actuator_driver;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] front_wheel;
    logic [1:0] motor;
    logic       servo_pwm, motor_in1, motor_in2, motor_en, dead_active;
    logic [4:0] outv;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    actuator_driver dut (
        .clk         (clk),
        .rst         (rst),
        .front_wheel (front_wheel),
        .motor       (motor),
        .servo_pwm   (servo_pwm),
        .motor_in1   (motor_in1),
        .motor_in2   (motor_in2),
        .motor_en    (motor_en),
        .dead_active (dead_active)
    );

    assign outv = {servo_pwm, motor_in1, motor_in2, motor_en, dead_active};

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] cmd;
        logic       in1;
        logic       in2;
        logic       en;
        logic       chk_en;
        logic       dead;
    } drv_vec_t;

    typedef struct {
        logic [2:0]  next_code;
        int unsigned exp_hi;
    } steer_vec_t;

    drv_vec_t   drv_tbl [11];
    steer_vec_t steer_tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic wait_servo_high(output bit ok);
        int unsigned n = 0;
        while (servo_pwm !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        ok = (servo_pwm === 1'b1);
    endtask

    // Called at the first high sample of a frame; returns at the first high sample of the next one
    task automatic measure_frame(input logic [2:0] next_code, output int unsigned hi,
                                 output int unsigned per);
        hi  = 0;
        per = 0;
        while (servo_pwm === 1'b1 && per < 20000) begin
            if (per == 300) front_wheel = next_code;
            per++;
            hi++;
            @(negedge clk);
        end
        while (servo_pwm !== 1'b1 && per < 20000) begin
            if (per == 300) front_wheel = next_code;
            per++;
            @(negedge clk);
        end
    endtask

    task automatic count_en(input int unsigned n, output int unsigned hi);
        hi = 0;
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            if (motor_en === 1'b1) hi++;
        end
    endtask

    task automatic count_dead(input int unsigned sw_at, input logic [1:0] sw_cmd,
                              output int unsigned len, output int unsigned bad);
        int unsigned n = 0;
        len = 0;
        bad = 0;
        while (dead_active !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        while (dead_active === 1'b1 && len < 2000) begin
            len++;
            if (motor_in1 !== 1'b0 || motor_in2 !== 1'b0 || motor_en !== 1'b0) bad++;
            if (len == sw_at) motor = sw_cmd;
            @(negedge clk);
        end
    endtask

    task automatic apply_cmd(input logic [1:0] cmd);
        @(negedge clk);
        motor = cmd;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned hi, per, len, bad;
        bit ok;

        drv_tbl[0]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        drv_tbl[1]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drv_tbl[2]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drv_tbl[3]  = '{2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        drv_tbl[4]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        drv_tbl[5]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drv_tbl[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drv_tbl[7]  = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        drv_tbl[8]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        drv_tbl[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        drv_tbl[10] = '{2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        steer_tbl[0] = '{3'd0, 750};
        steer_tbl[1] = '{3'd7, 500};
        steer_tbl[2] = '{3'd4, 750};
        steer_tbl[3] = '{3'd1, 1000};
        steer_tbl[4] = '{3'd3, 625};
        steer_tbl[5] = '{3'd2, 875};

        rst         = 1'b0;
        front_wheel = 3'd2;
        motor       = 2'b00;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(outv), 32'd0);
        rst = 1'b1;

        // STOP -> FWD: bridge follows on the second edge after the change
        @(negedge clk);
        motor = 2'b01;
        @(posedge clk);
        #1;
        check("fwd_edge1_in1", 32'(motor_in1), 32'd0);
        @(posedge clk);
        #1;
        check("fwd_edge2_in1", 32'(motor_in1), 32'd1);
        check("fwd_edge2_in2", 32'(motor_in2), 32'd0);

        for (int i = 0; i < 11; i++) begin
            apply_cmd(drv_tbl[i].cmd);
            check($sformatf("tbl%0d_in1", i), 32'(motor_in1), 32'(drv_tbl[i].in1));
            check($sformatf("tbl%0d_in2", i), 32'(motor_in2), 32'(drv_tbl[i].in2));
            check($sformatf("tbl%0d_dead", i), 32'(dead_active), 32'(drv_tbl[i].dead));
            if (drv_tbl[i].chk_en)
                check($sformatf("tbl%0d_en", i), 32'(motor_en), 32'(drv_tbl[i].en));
        end

        count_en(200, hi);
        check("fwd_en_duty_200", hi, 140);

        // FWD -> BWD reversal
        @(negedge clk);
        motor = 2'b10;
        count_dead(0, 2'b00, len, bad);
        check("rev_dead_len", len, 500);
        check("rev_dead_outputs_low", bad, 0);
        check("rev_after_in1", 32'(motor_in1), 32'd0);
        check("rev_after_in2", 32'(motor_in2), 32'd1);
        count_en(100, hi);
        check("bwd_en_duty_100", hi, 70);

        // BWD -> FWD, then back to BWD mid-dead: dead-time still runs to completion
        @(negedge clk);
        motor = 2'b01;
        count_dead(100, 2'b10, len, bad);
        check("samedir_dead_len", len, 500);
        check("samedir_dead_outputs_low", bad, 0);
        check("samedir_after_in1", 32'(motor_in1), 32'd0);
        check("samedir_after_in2", 32'(motor_in2), 32'd1);

        // Brake preempts the dead-time
        @(negedge clk);
        motor = 2'b01;
        count_dead(100, 2'b11, len, bad);
        check("preempt_dead_len", len, 101);
        check("preempt_brake_bridge", 32'(outv[4:1]) & 32'h7, 32'h7);
        check("preempt_brake_dead", 32'(dead_active), 32'd0);
        apply_cmd(2'b00);
        check("preempt_stop_motor_outs", 32'(outv[3:0]), 32'd0);

        // Mid-frame asynchronous reset
        @(negedge clk);
        motor       = 2'b01;
        front_wheel = 3'd4;
        wait_servo_high(ok);
        check("pre_reset_servo_found", 32'(ok), 32'd1);
        repeat (100) @(negedge clk);
        check("pre_reset_servo_high", 32'(servo_pwm), 32'd1);
        check("pre_reset_in1", 32'(motor_in1), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("midframe_reset_outputs", 32'(outv), 32'd0);
        motor       = 2'b00;
        front_wheel = 3'd2;
        @(negedge clk);
        check("reset_held_outputs", 32'(outv), 32'd0);
        rst = 1'b1;

        wait_servo_high(ok);
        check("first_frame_started", 32'(ok), 32'd1);
        for (int i = 0; i < 6; i++) begin
            measure_frame(steer_tbl[i].next_code, hi, per);
            check($sformatf("frame%0d_high", i), hi, steer_tbl[i].exp_hi);
            check($sformatf("frame%0d_period", i), per, 10000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
